// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scan driver.
// Provides the dark pattern, the 16-entry active-low glyph table ({a,b,c,d,e,f,g})
// and a helper that maps a nibble to its glyph, with 10..15 optionally suppressed.
package seg_pkg;

   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   // Entry n is the active-low pattern for value n (index 15 is leftmost).
   localparam logic [15:0][6:0] GLYPH_TBL = {
      7'b0111000,   // F
      7'b0110000,   // E
      7'b1000010,   // d
      7'b0110001,   // C
      7'b1100000,   // b
      7'b0001000,   // A
      7'b0000100,   // 9
      7'b0000000,   // 8
      7'b0001111,   // 7
      7'b0100000,   // 6
      7'b0100100,   // 5
      7'b1001100,   // 4
      7'b0000110,   // 3
      7'b0010010,   // 2
      7'b1001111,   // 1
      7'b0000001    // 0
   };

   // Nibble to glyph; without hex support values above 9 stay dark.
   function automatic logic [6:0] glyph(input logic [3:0] nibble, input logic hex_en);
      logic [6:0] result;
      result = GLYPH_TBL[nibble];
      if (!hex_en && (nibble > 4'd9)) begin
         result = SEG_BLANK;
      end
      return result;
   endfunction

endpackage

// File: rtl/seg_glyph_rom.sv
// Combinational nibble to seven-segment decoder.
// Ports: nibble (value 0..15) -> seg_c (active-low {a,b,c,d,e,f,g}).
// HEX_EN = 0 leaves values 10..15 dark.
module seg_glyph_rom
   import seg_pkg::*;
#(
   parameter int unsigned HEX_EN = 1
) (
   input  logic [3:0] nibble,
   output logic [6:0] seg_c
);

   assign seg_c = glyph(nibble, HEX_EN != 0);

endmodule

// File: rtl/seg_scan_display.sv
// Time-multiplexed seven-segment driver for NUM_DIGITS common-anode digits.
// Ports: clk, rst (sync, active-high); load captures digits_in (packed nibbles,
// digit 0 in [3:0]), blank_in, blink_in, dp_in and lzb_en into shadow registers.
// AN (active-low digit enables), SEG (active-low {a..g}) and DP are registered.
// Outputs are computed from the next-state counters and shadows so the pins
// always line up with the slot/index registers and a load shows on its own edge.
module seg_scan_display
   import seg_pkg::*;
#(
   parameter int unsigned NUM_DIGITS   = 4,
   parameter int unsigned REFRESH_DIV  = 100000,
   parameter int unsigned GUARD        = 2,
   parameter int unsigned BLINK_FRAMES = 32,
   parameter int unsigned HEX_EN       = 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      load,
   input  logic [4*NUM_DIGITS-1:0]   digits_in,
   input  logic [NUM_DIGITS-1:0]     blank_in,
   input  logic [NUM_DIGITS-1:0]     blink_in,
   input  logic [NUM_DIGITS-1:0]     dp_in,
   input  logic                      lzb_en,
   output logic [NUM_DIGITS-1:0]     AN,
   output logic [6:0]                SEG,
   output logic                      DP
);

   localparam int unsigned DIG_W   = 4 * NUM_DIGITS;
   localparam int unsigned SLOT_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int unsigned IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int unsigned FRAME_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   logic [DIG_W-1:0]      digits_q, digits_d;
   logic [NUM_DIGITS-1:0] blank_q, blank_d;
   logic [NUM_DIGITS-1:0] blink_q, blink_d;
   logic [NUM_DIGITS-1:0] dp_mask_q, dp_mask_d;
   logic                  lzb_q, lzb_d;
   logic [SLOT_W-1:0]     slot_q, slot_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic [FRAME_W-1:0]    frame_q, frame_d;
   logic                  phase_q, phase_d;
   logic [NUM_DIGITS-1:0] an_q, an_d;
   logic [6:0]            seg_q, seg_d;
   logic                  dp_q, dp_d;

   logic                  slot_wrap, frame_end;
   logic [NUM_DIGITS-1:0] lead_zero;
   logic [3:0]            sel_nib;
   logic                  sel_dark, sel_dp;
   logic [6:0]            glyph_c;

   // Shadow capture and scan/blink counters.
   always_comb begin
      digits_d  = digits_q;
      blank_d   = blank_q;
      blink_d   = blink_q;
      dp_mask_d = dp_mask_q;
      lzb_d     = lzb_q;
      frame_d   = frame_q;
      phase_d   = phase_q;

      if (load) begin
         digits_d  = digits_in;
         blank_d   = blank_in;
         blink_d   = blink_in;
         dp_mask_d = dp_in;
         lzb_d     = lzb_en;
      end

      slot_wrap = (slot_q == SLOT_W'(REFRESH_DIV - 1));
      frame_end = slot_wrap && (idx_q == IDX_W'(NUM_DIGITS - 1));

      slot_d = slot_wrap ? '0 : slot_q + SLOT_W'(1);
      idx_d  = idx_q;
      if (slot_wrap) begin
         idx_d = frame_end ? '0 : idx_q + IDX_W'(1);
      end

      if (frame_end) begin
         if (frame_q == FRAME_W'(BLINK_FRAMES - 1)) begin
            frame_d = '0;
            phase_d = ~phase_q;
         end else begin
            frame_d = frame_q + FRAME_W'(1);
         end
      end
   end

   // Leading-zero map (digit 0 exempt) and selection of the digit being scanned.
   always_comb begin
      logic run_zero;
      run_zero  = 1'b1;
      lead_zero = '0;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         run_zero     = run_zero && (digits_d[4*i +: 4] == 4'd0);
         lead_zero[i] = run_zero && (i != 0);
      end

      sel_nib  = 4'd0;
      sel_dark = 1'b1;
      sel_dp   = 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (idx_d == IDX_W'(i)) begin
            sel_nib  = digits_d[4*i +: 4];
            sel_dark = blank_d[i] | (blink_d[i] & phase_d) | (lzb_d & lead_zero[i]);
            sel_dp   = dp_mask_d[i];
         end
      end
   end

   seg_glyph_rom #(
      .HEX_EN (HEX_EN)
   ) u_glyph_rom (
      .nibble (sel_nib),
      .seg_c  (glyph_c)
   );

   // Pin values: all dark during the guard interval, else drive the selected digit.
   always_comb begin
      an_d  = '1;
      seg_d = SEG_BLANK;
      dp_d  = 1'b1;
      if (!(32'(slot_d) < GUARD)) begin
         for (int i = 0; i < NUM_DIGITS; i++) begin
            an_d[i] = (idx_d != IDX_W'(i));
         end
         if (!sel_dark) begin
            seg_d = glyph_c;
            dp_d  = ~sel_dp;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         digits_q  <= '0;
         blank_q   <= '1;
         blink_q   <= '0;
         dp_mask_q <= '0;
         lzb_q     <= 1'b0;
         slot_q    <= '0;
         idx_q     <= '0;
         frame_q   <= '0;
         phase_q   <= 1'b0;
         an_q      <= '1;
         seg_q     <= SEG_BLANK;
         dp_q      <= 1'b1;
      end else begin
         digits_q  <= digits_d;
         blank_q   <= blank_d;
         blink_q   <= blink_d;
         dp_mask_q <= dp_mask_d;
         lzb_q     <= lzb_d;
         slot_q    <= slot_d;
         idx_q     <= idx_d;
         frame_q   <= frame_d;
         phase_q   <= phase_d;
         an_q      <= an_d;
         seg_q     <= seg_d;
         dp_q      <= dp_d;
      end
   end

   assign AN  = an_q;
   assign SEG = seg_q;
   assign DP  = dp_q;

endmodule

// File: tb/tb_seg_scan_display.sv
// Directed bench for seg_scan_display: two instances (hex on / hex off) with a
// short refresh divider; expected pins derive from elapsed cycles since reset
// and hand-written glyph patterns per digit.
module tb_seg_scan_display;

   localparam int unsigned N  = 4;
   localparam int unsigned RD = 8;
   localparam int unsigned G  = 2;
   localparam int unsigned BF = 2;

   localparam logic [6:0] BL = 7'b1111111;
   localparam logic [6:0] G0 = 7'b0000001;
   localparam logic [6:0] G1 = 7'b1001111;
   localparam logic [6:0] G2 = 7'b0010010;
   localparam logic [6:0] G3 = 7'b0000110;
   localparam logic [6:0] G4 = 7'b1001100;
   localparam logic [6:0] G5 = 7'b0100100;
   localparam logic [6:0] G6 = 7'b0100000;
   localparam logic [6:0] G7 = 7'b0001111;
   localparam logic [6:0] G8 = 7'b0000000;
   localparam logic [6:0] G9 = 7'b0000100;
   localparam logic [6:0] GA = 7'b0001000;
   localparam logic [6:0] GB = 7'b1100000;
   localparam logic [6:0] GC = 7'b0110001;
   localparam logic [6:0] GD = 7'b1000010;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        load = 1'b0;
   logic [15:0] digits_in = '0;
   logic [3:0]  blank_in = '0;
   logic [3:0]  blink_in = '0;
   logic [3:0]  dp_in = '0;
   logic        lzb_en = 1'b0;

   logic [3:0]  an, an_nh;
   logic [6:0]  seg, seg_nh;
   logic        dp, dp_nh;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;

   logic [6:0] e_seg [4];
   logic [6:0] e_seg_nh [4];
   logic [3:0] e_dp;
   logic [3:0] e_blink;

   always #5 clk = ~clk;

   seg_scan_display #(
      .NUM_DIGITS(N), .REFRESH_DIV(RD), .GUARD(G), .BLINK_FRAMES(BF), .HEX_EN(1)
   ) dut (
      .clk(clk), .rst(rst), .load(load), .digits_in(digits_in), .blank_in(blank_in),
      .blink_in(blink_in), .dp_in(dp_in), .lzb_en(lzb_en), .AN(an), .SEG(seg), .DP(dp)
   );

   seg_scan_display #(
      .NUM_DIGITS(N), .REFRESH_DIV(RD), .GUARD(G), .BLINK_FRAMES(BF), .HEX_EN(0)
   ) dut_nohex (
      .clk(clk), .rst(rst), .load(load), .digits_in(digits_in), .blank_in(blank_in),
      .blink_in(blink_in), .dp_in(dp_in), .lzb_en(lzb_en), .AN(an_nh), .SEG(seg_nh),
      .DP(dp_nh)
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %b expected %b (cycle %0d)", tag, got[6:0], exp[6:0], cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   // Expected pins for the current cycle since the last reset edge.
   task automatic check_now();
      int         slot, idx;
      bit         ph;
      logic [3:0] xa;
      logic [6:0] xs, xsn;
      logic       xd;
      slot = cyc % RD;
      idx  = (cyc / RD) % N;
      ph   = ((cyc / (RD * N * BF)) % 2) == 1;
      xa = 4'hf; xs = BL; xsn = BL; xd = 1'b1;
      if (slot >= G) begin
         xa = ~(4'b0001 << idx);
         if (!(e_blink[idx] && ph)) begin
            xs  = e_seg[idx];
            xsn = e_seg_nh[idx];
            xd  = e_dp[idx];
         end
      end
      check_val("an", 32'(an), 32'(xa));
      check_val("seg", 32'(seg), 32'(xs));
      check_val("dp", 32'(dp), 32'(xd));
      check_val("an_nohex", 32'(an_nh), 32'(xa));
      check_val("seg_nohex", 32'(seg_nh), 32'(xsn));
   endtask

   task automatic run_cycles(input int n);
      for (int k = 0; k < n; k++) begin
         tick();
         check_now();
      end
   endtask

   // segs/segs_nh packed {d3,d2,d1,d0}; dpx is the expected DP pin per digit.
   task automatic set_exp(input logic [27:0] segs, input logic [27:0] segs_nh,
                          input logic [3:0] dpx, input logic [3:0] blk);
      for (int i = 0; i < 4; i++) begin
         e_seg[i]    = segs[7*i +: 7];
         e_seg_nh[i] = segs_nh[7*i +: 7];
      end
      e_dp    = dpx;
      e_blink = blk;
   endtask

   task automatic do_load(input logic [15:0] d, input logic [3:0] bl, input logic [3:0] bk,
                          input logic [3:0] dpm, input logic lz);
      digits_in = d; blank_in = bl; blink_in = bk; dp_in = dpm; lzb_en = lz;
      load = 1'b1;
      tick();
      check_now();
      load = 1'b0;
   endtask

   // Reset edge with a load pending that must be ignored.
   task automatic do_reset();
      rst = 1'b1;
      load = 1'b1; digits_in = 16'h8888; blank_in = 4'h0; dp_in = 4'hf; lzb_en = 1'b0;
      tick();
      cyc = 0;
      check_val("rst_an", 32'(an), 32'(4'hf));
      check_val("rst_seg", 32'(seg), 32'(BL));
      check_val("rst_dp", 32'(dp), 32'(1'b1));
      rst = 1'b0;
      load = 1'b0;
      set_exp({BL, BL, BL, BL}, {BL, BL, BL, BL}, 4'hf, 4'h0);
   endtask

   initial begin
      set_exp({BL, BL, BL, BL}, {BL, BL, BL, BL}, 4'hf, 4'h0);
      do_reset();
      run_cycles(100);

      set_exp({G1, G2, G3, G4}, {G1, G2, G3, G4}, 4'hf, 4'h0);
      do_load(16'h1234, 4'h0, 4'h0, 4'h0, 1'b0);
      run_cycles(40);

      set_exp({BL, BL, G7, G0}, {BL, BL, G7, G0}, 4'hf, 4'h0);
      do_load(16'h0070, 4'h0, 4'h0, 4'h0, 1'b1);
      run_cycles(32);
      set_exp({G0, G0, G7, G0}, {G0, G0, G7, G0}, 4'hf, 4'h0);
      do_load(16'h0070, 4'h0, 4'h0, 4'h0, 1'b0);
      run_cycles(32);

      set_exp({GA, GB, GC, GD}, {BL, BL, BL, BL}, 4'hf, 4'h0);
      do_load(16'hABCD, 4'h0, 4'h0, 4'h0, 1'b0);
      run_cycles(32);

      set_exp({G9, G9, BL, G9}, {G9, G9, BL, G9}, 4'hf, 4'h0);
      do_load(16'h9999, 4'b0010, 4'h0, 4'h0, 1'b0);
      run_cycles(32);

      // Reset in the middle of a lit slot.
      while ((cyc % RD) != 4) run_cycles(1);
      do_reset();
      run_cycles(10);

      set_exp({G1, G2, G3, G4}, {G1, G2, G3, G4}, 4'b1101, 4'b0001);
      do_load(16'h1234, 4'h0, 4'b0001, 4'b0010, 1'b0);
      run_cycles(190);

      // Load landing on the first lit edge of a slot.
      while ((cyc % RD) != 1) run_cycles(1);
      set_exp({G5, G6, G7, G8}, {G5, G6, G7, G8}, 4'hf, 4'h0);
      do_load(16'h5678, 4'h0, 4'h0, 4'h0, 1'b0);
      run_cycles(6);

      // Load landing on a slot-wrap edge.
      while ((cyc % RD) != 7) run_cycles(1);
      set_exp({G4, G3, G2, G1}, {G4, G3, G2, G1}, 4'hf, 4'h0);
      do_load(16'h4321, 4'h0, 4'h0, 4'h0, 1'b0);
      run_cycles(34);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
